register_writeback_unit: RTL
============================

Name: register_writeback_unit

Overview:
- Write side of the register file: memory-to-writeback (MEM/WB) pipeline latch, result-source selection, and the 16-entry architectural register file with one write port.
- Provides the three read ports consumed by operand fetch: rs1, rs2 and R15 (the return-address register).
- Write-through bypass: a register being written this cycle reads back its new value.
- Sits between the memory-access stage and operand fetch; closes the pipeline loop.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 16, number of architectural registers.
- ADDR_W, 4, register index width (log2 NREGS).
- RA_REG, 15, return-address register written by call.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  freezes the WB latch and suppresses the register-file write.
- flush  input  1  invalidates the WB latch at the next edge.
- in_valid  input  1  MEM stage holds a valid instruction.
- in_pc  input  DATA_W  PC of the MEM-stage instruction.
- in_inst  input  32  instruction word; rd = in_inst[25:22].
- in_alu_result  input  DATA_W  ALU result.
- in_ld_result  input  DATA_W  load data from memory.
- in_isLd  input  1  instruction is a load.
- in_isCall  input  1  instruction is a call.
- in_isWb  input  1  instruction writes a register.
- rd_addr1  input  ADDR_W  read-port-1 index.
- rd_addr2  input  ADDR_W  read-port-2 index.
- reg_data1  output  DATA_W  read-port-1 data.
- reg_data2  output  DATA_W  read-port-2 data.
- reg_data15  output  DATA_W  contents of RA_REG.
- wb_en  output  1  a write commits at the next rising edge.
- wb_addr  output  ADDR_W  write index.
- wb_data  output  DATA_W  write data.

Behaviour:
- Reset (async, rst=1): latch valid=0; all latch fields=0; all NREGS registers=0; wb_en=0, wb_addr=0, wb_data=0. Outputs are valid immediately on reset assertion, not at the next edge.
- Latch update on a rising edge, in priority order:
  - flush=1: valid<=0; other fields are don't-care. Flush wins over stall.
  - else stall=1: hold all fields.
  - else: capture in_valid, in_pc, in_inst, in_alu_result, in_ld_result, in_isLd, in_isCall, in_isWb.
- Result selection, combinational from the latch:
  - isCall: wb_data = pc + 4.
  - else isLd: wb_data = ld_result.
  - else: wb_data = alu_result.
  - pc + 4 is modulo 2^DATA_W; carry is discarded.
- Destination: wb_addr = isCall ? RA_REG : inst[25:22]. Call overrides isWb and always writes.
- Write enable: wb_en = valid & (isWb | isCall) & ~stall.
- Register file: at the rising edge with wb_en=1, regs[wb_addr] <= wb_data. R0 is an ordinary writable register.
- Latency: an instruction captured at edge N commits at edge N+1. Its value is readable through the bypass during cycle N+1 and from storage from cycle N+2.
- Read ports are combinational. If wb_en=1 and the port index equals wb_addr, the port returns wb_data; otherwise it returns storage.
  - Applies to reg_data1, reg_data2 and reg_data15; reg_data15 compares against RA_REG.
  - Both ports reading the write target both see the bypassed value.
- Stall while holding a valid write: the write is deferred, not lost. It commits exactly once, at the first non-stalled edge.
- Flush while holding an uncommitted write: the current-cycle write still commits if stall=0, because flush acts on the latch, not the in-flight write. When flush and stall are both high, flush wins, so the held write is dropped.
- Reset mid-operation: in-flight writes are discarded and the register file is cleared.

Decomposition:
- Shared package: DATA_W, ADDR_W, NREGS, RA_REG, the rd field position (25:22) and the PC increment (4).
- Natural sub-module: register_file_16x32 (storage, one write port, three bypassed read ports).
- The latch and result mux stay in the top module.

Test Plan:
- Reset, then read all 16 addresses -> every reg_data = 0, wb_en = 0.
- ALU op: isWb=1, rd=3, alu_result=0x0000_1234, with rd_addr1=3 in the following cycle -> wb_en=1, wb_addr=3, reg_data1=0x1234 via bypass in that cycle and from storage in the cycle after.
- Load, rd=7, ld_result=0xDEAD_BEEF, alu_result=0x5 -> regs[7]=0xDEADBEEF. Call with pc=0x100, inst[25:22]=2 -> regs[15]=0x104, regs[2] unchanged, reg_data15=0x104 during the write cycle.
- Stall held 3 cycles on a valid write to r5=0x55 -> wb_en=0 for 3 cycles; r5 written once at the first non-stalled edge. flush+stall together -> latch valid=0 and the held write is never committed.
- Assert rst asynchronously mid-cycle while wb_en=1 (rd=9) -> outputs clear without waiting for a clock edge; regs[9] stays 0.

Source files
------------

// File: rtl/register_writeback_unit_pkg.sv
// Shared widths, register-file geometry and the MEM/WB latch record for the writeback stage.
package register_writeback_unit_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int INST_W = 32;
  localparam int RD_MSB = 25;
  localparam int RD_LSB = 22;

  localparam logic [ADDR_W-1:0] RA_REG = ADDR_W'(15);
  localparam logic [DATA_W-1:0] PC_INC = DATA_W'(4);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ld_result;
    logic              is_ld;
    logic              is_call;
    logic              is_wb;
  } wb_latch_t;

  function automatic logic [ADDR_W-1:0] rd_field(input logic [INST_W-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/register_writeback_unit_regfile.sv
// 16x32 architectural register file: one write port, three combinational read ports
// with write-through bypass so a register being written reads back its new value.
module register_file_16x32
  import register_writeback_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] rdata15_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // R0 is an ordinary register here; nothing hardwires it to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o  = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o  = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
  assign rdata15_o = (we_i && (waddr_i == RA_REG))   ? wdata_i : regs_q[RA_REG];

endmodule

// File: rtl/register_writeback_unit.sv
// MEM/WB pipeline latch, result-source selection and register-file write port;
// feeds the rs1/rs2/R15 read ports back to operand fetch.
module register_writeback_unit
  import register_writeback_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_ld_result,
  input  logic              in_isLd,
  input  logic              in_isCall,
  input  logic              in_isWb,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] reg_data1,
  output logic [DATA_W-1:0] reg_data2,
  output logic [DATA_W-1:0] reg_data15,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  wb_latch_t latch_q, latch_d;

  // Handshake: in_valid has no ready; stall is the only backpressure, and upstream
  // must hold its instruction while stall is high. Flush beats stall.
  always_comb begin
    latch_d = latch_q;
    if (flush) begin
      latch_d.valid = 1'b0;
    end else if (!stall) begin
      latch_d.valid      = in_valid;
      latch_d.pc         = in_pc;
      latch_d.inst       = in_inst;
      latch_d.alu_result = in_alu_result;
      latch_d.ld_result  = in_ld_result;
      latch_d.is_ld      = in_isLd;
      latch_d.is_call    = in_isCall;
      latch_d.is_wb      = in_isWb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) latch_q <= '0;
    else     latch_q <= latch_d;
  end

  // A held write is only deferred by stall: it stays in the latch until a free edge.
  always_comb begin
    if (latch_q.is_call)    wb_data = latch_q.pc + PC_INC;
    else if (latch_q.is_ld) wb_data = latch_q.ld_result;
    else                    wb_data = latch_q.alu_result;
  end

  assign wb_addr = latch_q.is_call ? RA_REG : rd_field(latch_q.inst);
  assign wb_en   = latch_q.valid & (latch_q.is_wb | latch_q.is_call) & ~stall;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{latch_q.inst[INST_W-1:RD_MSB+1], latch_q.inst[RD_LSB-1:0]};

  register_file_16x32 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr1_i  (rd_addr1),
    .raddr2_i  (rd_addr2),
    .rdata1_o  (reg_data1),
    .rdata2_o  (reg_data2),
    .rdata15_o (reg_data15)
  );

endmodule
